// File: rtl/vid_rdata_fifo_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vid_rdata_fifo_reader_if                                             |
// | Display timing, read-FIFO and pixel/debug bundle of the FIFO reader. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vid_rdata_fifo_reader_if;
  logic        VGA_Sync;
  logic        Vga_De;
  logic        rdata_fifo_empty;
  logic [15:0] rdata_fifo_rd_data;
  logic        rdata_fifo_rd_en;
  logic        R_Rd_trigger;
  logic [15:0] O_Pix_Data;
  logic        O_Pix_Vld;
  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [15:0] underflow_cnt;
  logic        line_err;
  logic        frame_err;

  modport master (
    output VGA_Sync, Vga_De, rdata_fifo_empty, rdata_fifo_rd_data,
    input  rdata_fifo_rd_en, R_Rd_trigger, O_Pix_Data, O_Pix_Vld,
    input  hcnt, vcnt, underflow_cnt, line_err, frame_err
  );

  modport slave (
    input  VGA_Sync, Vga_De, rdata_fifo_empty, rdata_fifo_rd_data,
    output rdata_fifo_rd_en, R_Rd_trigger, O_Pix_Data, O_Pix_Vld,
    output hcnt, vcnt, underflow_cnt, line_err, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/vid_rdata_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vid_rdata_fifo_reader                                                |
// | Paces read-data FIFO reads against display DE, triggers frame DMA.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vid_rdata_fifo_reader #(
  parameter int          H_ACTIVE = 1280,
  parameter int          V_ACTIVE = 720,
  parameter logic [15:0] FILL_PIX = 16'h0000,
  parameter int          ARM_WAIT = 64
) (
  input  logic                   I_Clk,
  input  logic                   Rst,
  vid_rdata_fifo_reader_if.slave bus
);

  localparam logic [15:0] H_LEN    = 16'(H_ACTIVE);
  localparam logic [15:0] V_LEN    = 16'(V_ACTIVE);
  localparam logic [15:0] ARM_LAST = 16'(ARM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] arm_cnt;
  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [15:0] underflow_cnt;
  logic [15:0] vcnt_nxt;
  logic        de_q;
  logic        rd_q;
  logic        trigger;
  logic        pix_vld;
  logic        line_err;
  logic        frame_err;
  logic        sync;
  logic        de;
  logic        empty;
  logic        rd_en;
  logic        fall;
  logic        counting;

  assign sync     = bus.VGA_Sync;
  assign de       = bus.Vga_De;
  assign empty    = bus.rdata_fifo_empty;
  assign fall     = de_q & ~de;
  assign counting = (state == ARM) || (state == ACTIVE);
  assign vcnt_nxt = fall ? vcnt + 16'd1 : vcnt;

  // A sync cycle is handled as ARM, so it never reads even when De is high.
  assign rd_en = ~Rst & ~sync & de & ~empty & (state == ACTIVE);

  always_ff @(posedge I_Clk) begin
    if (Rst) begin
      state         <= IDLE;
      arm_cnt       <= 16'd0;
      hcnt          <= 16'd0;
      vcnt          <= 16'd0;
      underflow_cnt <= 16'd0;
      de_q          <= 1'b0;
      rd_q          <= 1'b0;
      trigger       <= 1'b0;
      pix_vld       <= 1'b0;
      line_err      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      de_q    <= de;
      rd_q    <= rd_en;
      trigger <= 1'b0;
      pix_vld <= de & (sync | (state != IDLE));
      if (sync) begin
        state         <= ARM;
        arm_cnt       <= 16'd0;
        trigger       <= 1'b1;
        hcnt          <= {15'd0, de};
        vcnt          <= 16'd0;
        underflow_cnt <= {15'd0, de};
        if (state == ACTIVE) frame_err <= 1'b1;
      end else begin
        case (state)
          ARM: begin
            if (arm_cnt == ARM_LAST) state <= ACTIVE;
            else arm_cnt <= arm_cnt + 16'd1;
          end
          ACTIVE: begin
            if (vcnt_nxt >= V_LEN) state <= DONE;
          end
          default: ;
        endcase
        if (counting) begin
          if (de) begin
            hcnt <= hcnt + 16'd1;
            // De during ARM is an early start: filled and counted as underflow.
            if ((state == ARM || empty) && underflow_cnt != 16'hFFFF)
              underflow_cnt <= underflow_cnt + 16'd1;
          end else if (fall) begin
            hcnt <= 16'd0;
            vcnt <= vcnt_nxt;
            if (hcnt != H_LEN) line_err <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.rdata_fifo_rd_en = rd_en;
  assign bus.R_Rd_trigger     = trigger;
  assign bus.O_Pix_Vld        = pix_vld;
  assign bus.O_Pix_Data       = !pix_vld ? 16'h0000 :
                                (rd_q ? bus.rdata_fifo_rd_data : FILL_PIX);
  assign bus.hcnt             = hcnt;
  assign bus.vcnt             = vcnt;
  assign bus.underflow_cnt    = underflow_cnt;
  assign bus.line_err         = line_err;
  assign bus.frame_err        = frame_err;

endmodule
`default_nettype wire

// File: tb/tb_vid_rdata_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vid_rdata_fifo_reader                                             |
// | Frame-scenario table, corner sequences and random traffic vs model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vid_rdata_fifo_reader;

  localparam int          H        = 8;
  localparam int          V        = 4;
  localparam logic [15:0] FILL     = 16'hF111;
  localparam int          ARM_WAIT = 6;
  localparam logic [15:0] STEP     = 16'h0013;

  localparam int M_IDLE = 0, M_ARM = 1, M_ACTIVE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fifo_word = 16'h1000;

  vid_rdata_fifo_reader_if bus();

  vid_rdata_fifo_reader #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FILL_PIX (FILL),
    .ARM_WAIT (ARM_WAIT)
  ) dut (
    .I_Clk (clk),
    .Rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: each read presents the next word of an arithmetic sequence.
  assign bus.rdata_fifo_rd_data = fifo_word;
  always @(posedge clk) if (bus.rdata_fifo_rd_en) fifo_word <= fifo_word + STEP;

  int n_checks = 0;
  int n_pass   = 0;
  int n_reads  = 0;
  bit chk_en   = 1'b1;

  // Reference model, expressed as frame-level bookkeeping.
  int          m_mode = M_IDLE;
  int          m_arm_left = 0;
  bit          m_in_line = 1'b0;
  logic [15:0] m_h = 16'd0, m_v = 16'd0, m_uf = 16'd0, m_word = 16'h1000;
  bit          m_le = 1'b0, m_fe = 1'b0;
  bit          x_trig = 1'b0, x_vld = 1'b0;
  logic [15:0] x_pix = 16'd0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (!chk_en) return;
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit s, input bit d, input bit e, output bit rd);
    rd = !r && m_mode == M_ACTIVE && d && !e && !s;
    if (r) begin
      m_mode = M_IDLE; m_arm_left = 0; m_in_line = 1'b0;
      m_h = 16'd0; m_v = 16'd0; m_uf = 16'd0; m_le = 1'b0; m_fe = 1'b0;
      x_trig = 1'b0; x_vld = 1'b0; x_pix = 16'd0;
      return;
    end
    x_trig = s;
    x_vld  = d && (s || m_mode != M_IDLE);
    if (rd) m_word = m_word + STEP;
    x_pix  = !x_vld ? 16'h0000 : (rd ? m_word : FILL);
    if (s) begin
      if (m_mode == M_ACTIVE) m_fe = 1'b1;
      m_mode = M_ARM; m_arm_left = ARM_WAIT;
      m_h = d ? 16'd1 : 16'd0; m_v = 16'd0; m_uf = d ? 16'd1 : 16'd0;
    end else begin
      if (m_mode == M_ARM || m_mode == M_ACTIVE) begin
        if (d) begin
          m_h = m_h + 16'd1;
          if ((m_mode == M_ARM || e) && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
        end else if (m_in_line) begin
          if (m_h != 16'(H)) m_le = 1'b1;
          m_v = m_v + 16'd1; m_h = 16'd0;
        end
      end
      if (m_mode == M_ARM) begin
        m_arm_left--;
        if (m_arm_left == 0) m_mode = M_ACTIVE;
      end else if (m_mode == M_ACTIVE && m_v >= 16'(V)) begin
        m_mode = M_DONE;
      end
    end
    m_in_line = d;
  endtask

  task automatic cycle(input bit r, input bit s, input bit d, input bit e);
    bit rd;
    @(negedge clk);
    rst = r; bus.VGA_Sync = s; bus.Vga_De = d; bus.rdata_fifo_empty = e;
    #1;
    model_step(r, s, d, e, rd);
    chk("rd_en", {15'd0, bus.rdata_fifo_rd_en}, {15'd0, rd});
    if (bus.rdata_fifo_rd_en) n_reads++;
    @(posedge clk);
    #1;
    chk("trigger",   {15'd0, bus.R_Rd_trigger}, {15'd0, x_trig});
    chk("pix_vld",   {15'd0, bus.O_Pix_Vld},    {15'd0, x_vld});
    chk("pix_data",  bus.O_Pix_Data,            x_pix);
    chk("hcnt",      bus.hcnt,                  m_h);
    chk("vcnt",      bus.vcnt,                  m_v);
    chk("underflow", bus.underflow_cnt,         m_uf);
    chk("line_err",  {15'd0, bus.line_err},     {15'd0, m_le});
    chk("frame_err", {15'd0, bus.frame_err},    {15'd0, m_fe});
  endtask

  typedef struct {
    string       name;
    int          n_lines;
    int          short_line;
    int          empty_line;
    bit          sync_end;
    logic [15:0] exp_vcnt;
    logic [15:0] exp_uf;
    logic [15:0] exp_reads;
    bit          exp_le;
    bit          exp_fe_after;
  } vec_t;

  task automatic run_vector(input vec_t v);
    int reads0;
    cycle(1, 0, 0, 0);
    chk({v.name, " reset vcnt"}, bus.vcnt, 16'd0);
    cycle(0, 1, 0, 0);
    chk({v.name, " trigger"}, {15'd0, bus.R_Rd_trigger}, 16'd1);
    repeat (ARM_WAIT + 2) cycle(0, 0, 0, 0);
    reads0 = n_reads;
    for (int l = 0; l < v.n_lines; l++) begin
      for (int p = 0; p < ((l == v.short_line) ? H - 1 : H); p++)
        cycle(0, 0, 1, (l == v.empty_line) && (p >= 2) && (p <= 4));
      repeat (3) cycle(0, 0, 0, 0);
    end
    chk({v.name, " vcnt"},      bus.vcnt,          v.exp_vcnt);
    chk({v.name, " underflow"}, bus.underflow_cnt, v.exp_uf);
    chk({v.name, " reads"},     16'(n_reads - reads0), v.exp_reads);
    chk({v.name, " line_err"},  {15'd0, bus.line_err},  {15'd0, v.exp_le});
    chk({v.name, " frame_err"}, {15'd0, bus.frame_err}, 16'd0);
    if (v.sync_end) begin
      cycle(0, 1, 0, 0);
      chk({v.name, " resync trigger"},   {15'd0, bus.R_Rd_trigger}, 16'd1);
      chk({v.name, " resync vcnt"},      bus.vcnt,          16'd0);
      chk({v.name, " resync underflow"}, bus.underflow_cnt, 16'd0);
      chk({v.name, " resync line_err"},  {15'd0, bus.line_err},  {15'd0, v.exp_le});
      chk({v.name, " resync frame_err"}, {15'd0, bus.frame_err}, {15'd0, v.exp_fe_after});
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   reads0;
    int   run_left;
    bit   in_de;

    rst = 1'b1; bus.VGA_Sync = 1'b0; bus.Vga_De = 1'b0; bus.rdata_fifo_empty = 1'b0;

    //            name         lines short empty sync  vcnt   uf     reads  le    fe_after
    vecs[0] = '{"full_frame",   4,    -1,   -1,  1'b1, 16'd4, 16'd0, 16'd32, 1'b0, 1'b0};
    vecs[1] = '{"underflow",    4,    -1,    1,  1'b0, 16'd4, 16'd3, 16'd29, 1'b0, 1'b0};
    vecs[2] = '{"short_line",   4,     2,   -1,  1'b1, 16'd4, 16'd0, 16'd31, 1'b1, 1'b0};
    vecs[3] = '{"aborted",      2,    -1,    0,  1'b1, 16'd2, 16'd3, 16'd13, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Reset in the middle of a line while reads are flowing.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (ARM_WAIT + 2) cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0);
    chk("midreset rd_en before", {15'd0, bus.rdata_fifo_rd_en}, 16'd1);
    cycle(1, 0, 1, 0);
    chk("midreset pix_vld", {15'd0, bus.O_Pix_Vld}, 16'd0);
    chk("midreset hcnt",    bus.hcnt,               16'd0);
    reads0 = n_reads;
    repeat (10) cycle(0, 0, 1, 0);
    chk("midreset no reads idle", 16'(n_reads - reads0), 16'd0);
    cycle(0, 1, 1, 0);
    repeat (ARM_WAIT) cycle(0, 0, 1, 0);
    chk("midreset no reads arm", 16'(n_reads - reads0), 16'd0);
    chk("arm early underflow", bus.underflow_cnt, 16'(ARM_WAIT + 1));
    repeat (2) cycle(0, 0, 1, 0);
    chk("reads resume", 16'(n_reads - reads0), 16'd2);

    // Randomised traffic including syncs, resets and empties.
    cycle(1, 0, 0, 0);
    run_left = 0;
    in_de = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        in_de = !in_de;
        run_left = in_de ? int'($urandom_range(9, 6)) : int'($urandom_range(4, 1));
      end
      run_left--;
      cycle(($urandom_range(499, 0) == 0), ($urandom_range(119, 0) == 0),
            in_de, ($urandom_range(4, 0) == 0));
    end

    // Long underflow: counter must saturate.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (ARM_WAIT + 2) cycle(0, 0, 0, 0);
    chk_en = 1'b0;
    repeat (70000) cycle(0, 0, 1, 1);
    chk_en = 1'b1;
    cycle(0, 0, 1, 1);
    chk("underflow saturated", bus.underflow_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
